// File: rtl/cnu_stream_if.sv
// Streaming port bundle for cnu_stream: input message beats, output message beats and status.
// Macro CNU_OFFSET_EN adds the mode/beta controls for offset min-sum.
interface cnu_stream_if #(
    parameter int unsigned P      = 2,
    parameter int unsigned data_w = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [data_w*P-1:0]   in_q;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_w*P-1:0]   out_r;
    logic                  out_last;
    logic                  err_ovf;
    logic                  busy;
`ifdef CNU_OFFSET_EN
    logic                  mode;
    logic [data_w-2:0]     beta;

    modport slave (
        input  in_valid, in_q, in_last, out_ready, mode, beta,
        output in_ready, out_valid, out_r, out_last, err_ovf, busy
    );
    modport master (
        output in_valid, in_q, in_last, out_ready, mode, beta,
        input  in_ready, out_valid, out_r, out_last, err_ovf, busy
    );
`else
    modport slave (
        input  in_valid, in_q, in_last, out_ready,
        output in_ready, out_valid, out_r, out_last, err_ovf, busy
    );
    modport master (
        output in_valid, in_q, in_last, out_ready,
        input  in_ready, out_valid, out_r, out_last, err_ovf, busy
    );
`endif
endinterface

// File: rtl/cnu_stream.sv
// Streaming min-sum check node unit: accumulates min1/min2/index/sign over P-lane beats, then
// streams back scaled check-to-variable messages. Macro CNU_OFFSET_EN enables offset min-sum.
module cnu_stream #(
    parameter int unsigned D      = 8,
    parameter int unsigned P      = 2,
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = $clog2(D)
) (
    input  logic        clk,
    input  logic        rst_n,
    cnu_stream_if.slave cnu_io
);

    localparam int unsigned Beats = D / P;
    localparam int unsigned CntW  = $clog2(Beats + 1);
    localparam logic [data_w-2:0] MaxMag = {(data_w-1){1'b1}};

    typedef enum logic {StAccum, StEmit} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   n_q, n_d;
    logic [CntW-1:0]   ocnt_q, ocnt_d;
    logic [data_w-2:0] min1_q, min1_d;
    logic [data_w-2:0] min2_q, min2_d;
    logic [idx_w-1:0]  idx_q, idx_d;
    logic              sprod_q, sprod_d;
    logic [D-1:0]      sign_q, sign_d;
    logic              err_q, err_d;
`ifdef CNU_OFFSET_EN
    logic              mode_q, mode_d;
    logic [data_w-2:0] beta_q, beta_d;
`endif

    // Most negative code has no positive twin, so it saturates to MaxMag.
    function automatic logic [data_w-2:0] mag_of(input logic [data_w-1:0] v);
        if (v == {1'b1, {(data_w-1){1'b0}}}) begin
            return MaxMag;
        end
        return (data_w-1)'(v[data_w-1] ? -v : v);
    endfunction

    logic              in_acc;
    logic              beat_full;
    logic              out_acc;
    logic              out_is_last;

    assign in_acc      = cnu_io.in_valid && (state_q == StAccum);
    assign beat_full   = (cnt_q == CntW'(Beats - 1));
    assign out_is_last = (ocnt_q == (n_q - CntW'(1)));
    assign out_acc     = (state_q == StEmit) && cnu_io.out_ready;

    // Lane-sequential running minimum update for the beat currently on in_q.
    logic [data_w-2:0] a_min1, a_min2;
    logic [idx_w-1:0]  a_idx;
    logic              a_sprod;
    logic [D-1:0]      a_sign;
    logic [data_w-1:0] a_lane;
    logic [data_w-2:0] a_mag;
    logic [idx_w-1:0]  a_pos;

    always_comb begin
        a_min1  = min1_q;
        a_min2  = min2_q;
        a_idx   = idx_q;
        a_sprod = sprod_q;
        a_sign  = sign_q;
        a_lane  = '0;
        a_mag   = '0;
        a_pos   = '0;
        for (int k = 0; k < int'(P); k++) begin
            a_lane         = cnu_io.in_q[k*data_w +: data_w];
            a_mag          = mag_of(a_lane);
            a_pos          = idx_w'(int'(cnt_q) * int'(P) + k);
            a_sign[a_pos]  = a_lane[data_w-1];
            a_sprod        = a_sprod ^ a_lane[data_w-1];
            if (a_mag < a_min1) begin
                a_min2 = a_min1;
                a_min1 = a_mag;
                a_idx  = a_pos;
            end else if (a_mag < a_min2) begin
                a_min2 = a_mag;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        ocnt_d  = ocnt_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        sprod_d = sprod_q;
        sign_d  = sign_q;
        err_d   = err_q;
`ifdef CNU_OFFSET_EN
        mode_d  = mode_q;
        beta_d  = beta_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (in_acc) begin
                    min1_d  = a_min1;
                    min2_d  = a_min2;
                    idx_d   = a_idx;
                    sprod_d = a_sprod;
                    sign_d  = a_sign;
                    cnt_d   = cnt_q + CntW'(1);
`ifdef CNU_OFFSET_EN
                    if (cnt_q == '0) begin
                        mode_d = cnu_io.mode;
                        beta_d = cnu_io.beta;
                    end
`endif
                    if (cnu_io.in_last || beat_full) begin
                        state_d = StEmit;
                        n_d     = cnt_q + CntW'(1);
                        ocnt_d  = '0;
                        if (!cnu_io.in_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StEmit: begin
                if (out_acc) begin
                    if (out_is_last) begin
                        state_d = StAccum;
                        cnt_d   = '0;
                        min1_d  = MaxMag;
                        min2_d  = MaxMag;
                        idx_d   = '0;
                        sprod_d = 1'b0;
                    end else begin
                        ocnt_d = ocnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            n_q     <= '0;
            ocnt_q  <= '0;
            min1_q  <= MaxMag;
            min2_q  <= MaxMag;
            idx_q   <= '0;
            sprod_q <= 1'b0;
            sign_q  <= '0;
            err_q   <= 1'b0;
`ifdef CNU_OFFSET_EN
            mode_q  <= 1'b0;
            beta_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            ocnt_q  <= ocnt_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            sprod_q <= sprod_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
`ifdef CNU_OFFSET_EN
            mode_q  <= mode_d;
            beta_q  <= beta_d;
`endif
        end
    end

    // Output lanes are decoded from the held beat index, so they stay stable under backpressure.
    logic [data_w*P-1:0] o_data;
    logic [idx_w-1:0]    o_pos;
    logic [data_w-2:0]   o_mag;
    logic [data_w+1:0]   o_ext;
    logic [data_w-1:0]   o_scl;
    logic                o_sgn;

    always_comb begin
        o_data = '0;
        o_pos  = '0;
        o_mag  = '0;
        o_ext  = '0;
        o_scl  = '0;
        o_sgn  = 1'b0;
        if (state_q == StEmit) begin
            for (int k = 0; k < int'(P); k++) begin
                o_pos = idx_w'(int'(ocnt_q) * int'(P) + k);
                o_mag = (o_pos == idx_q) ? min2_q : min1_q;
                o_ext = (data_w+2)'(o_mag);
                o_scl = data_w'((o_ext + (o_ext << 1)) >> 2);
`ifdef CNU_OFFSET_EN
                if (mode_q) begin
                    o_scl = (o_mag > beta_q) ? data_w'(o_mag - beta_q) : '0;
                end
`endif
                o_sgn = sprod_q ^ sign_q[o_pos];
                o_data[k*data_w +: data_w] = o_sgn ? -o_scl : o_scl;
            end
        end
    end

    assign cnu_io.in_ready  = (state_q == StAccum);
    assign cnu_io.out_valid = (state_q == StEmit);
    assign cnu_io.busy      = (state_q == StEmit);
    assign cnu_io.out_last  = (state_q == StEmit) && out_is_last;
    assign cnu_io.out_r     = o_data;
    assign cnu_io.err_ovf   = err_q;

endmodule

// File: tb/tb_cnu_stream.sv
// Directed self-checking bench for cnu_stream (D=8, P=2, data_w=8).
module tb_cnu_stream;

    localparam int unsigned D = 8;
    localparam int unsigned P = 2;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnu_stream_if #(.P(P), .data_w(W)) ifc ();

    cnu_stream #(.D(D), .P(P), .data_w(W), .idx_w(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnu_io (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int norm_q [8] = '{5, -3, 7, -2, 9, 4, -6, 8};
    int norm_o [8] = '{-1, 1, -1, 2, -1, -1, 1, -1};

    function automatic logic [15:0] pack(input int a, input int b);
        logic [7:0] la;
        logic [7:0] lb;
        la = 8'(a);
        lb = 8'(b);
        return {lb, la};
    endfunction

    task automatic put_beat(input logic [15:0] d, input logic last);
        bit got;
        got = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_q     = d;
        ifc.in_last  = last;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = ifc.in_ready;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL put_beat_timeout: in_ready got 0 want 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic get_beat(output logic [15:0] d, output logic last);
        bit got;
        got = 1'b0;
        d = '0;
        last = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = ifc.out_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL get_beat_timeout: out_valid got 0 want 1 within 50 cycles");
        end
        d    = ifc.out_r;
        last = ifc.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (ifc.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
        end
        n_checks++;
        if (ifc.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid);
        end
        n_checks++;
        if (ifc.out_last !== 1'b0 || ifc.out_r !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_out: got last=%b r=%h want 0/0000", ifc.out_last, ifc.out_r);
        end
        n_checks++;
        if (ifc.err_ovf !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got err=%b busy=%b want 0/0", ifc.err_ovf, ifc.busy);
        end
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normalized();
        logic [15:0] d;
        logic        l;
        for (int b = 0; b < 3; b++) put_beat(pack(norm_q[2*b], norm_q[2*b+1]), 1'b0);
        n_checks++;
        if (ifc.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL norm_early_valid: got %b want 0", ifc.out_valid);
        end
        put_beat(pack(norm_q[6], norm_q[7]), 1'b1);
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL norm_latency: got valid=%b ready=%b busy=%b want 1/0/1",
                     ifc.out_valid, ifc.in_ready, ifc.busy);
        end
        for (int b = 0; b < 4; b++) begin
            get_beat(d, l);
            n_checks++;
            if (d !== pack(norm_o[2*b], norm_o[2*b+1]) || l !== (b == 3)) begin
                n_fail++;
                $display("FAIL norm_beat%0d: got r=%h last=%b want r=%h last=%b", b, d, l,
                         pack(norm_o[2*b], norm_o[2*b+1]), (b == 3));
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic        l;
        put_beat(pack(-128, 20), 1'b1);
        get_beat(d, l);
        n_checks++;
        if (d !== pack(15, -95) || l !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_beat: got r=%h last=%b want r=%h last=1", d, l, pack(15, -95));
        end
        n_checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_return: got ready=%b valid=%b want 1/0", ifc.in_ready,
                     ifc.out_valid);
        end
    endtask

    task automatic test_tie();
        logic [15:0] d;
        logic        l;
        put_beat(pack(4, 4), 1'b1);
        n_checks++;
        if (dut.idx_q !== 3'd0) begin
            n_fail++; $display("FAIL tie_idx: got %0d want 0", dut.idx_q);
        end
        get_beat(d, l);
        n_checks++;
        if (d !== pack(3, 3) || l !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_beat: got r=%h last=%b want r=%h last=1", d, l, pack(3, 3));
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic        l;
        ifc.out_ready = 1'b0;
        for (int b = 0; b < 3; b++) put_beat(pack(norm_q[2*b], norm_q[2*b+1]), 1'b0);
        put_beat(pack(norm_q[6], norm_q[7]), 1'b1);
        ifc.out_ready = 1'b1;
        get_beat(d, l);
        n_checks++;
        if (d !== pack(norm_o[0], norm_o[1]) || l !== 1'b0) begin
            n_fail++; $display("FAIL bp_beat0: got r=%h last=%b want r=%h last=0", d, l,
                               pack(norm_o[0], norm_o[1]));
        end
        ifc.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.out_r !== pack(norm_o[2], norm_o[3]) || ifc.out_last !== 1'b0 ||
                ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got r=%h last=%b ready=%b valid=%b want %h/0/0/1",
                         c, ifc.out_r, ifc.out_last, ifc.in_ready, ifc.out_valid,
                         pack(norm_o[2], norm_o[3]));
            end
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            get_beat(d, l);
            n_checks++;
            if (d !== pack(norm_o[2*b], norm_o[2*b+1]) || l !== (b == 3)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got r=%h last=%b want r=%h last=%b", b, d, l,
                         pack(norm_o[2*b], norm_o[2*b+1]), (b == 3));
            end
        end
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 4; b++) put_beat(pack(norm_q[2*b], norm_q[2*b+1]), 1'b0);
        n_checks++;
        if (ifc.err_ovf !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_close: got err=%b ready=%b valid=%b want 1/0/1", ifc.err_ovf,
                     ifc.in_ready, ifc.out_valid);
        end
        ifc.in_valid = 1'b1;
        ifc.in_q     = pack(1, 2);
        ifc.in_last  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 ||
                ifc.out_r !== pack(norm_o[2*b], norm_o[2*b+1]) || ifc.out_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL ovf_beat%0d: got valid=%b ready=%b r=%h last=%b want 1/0/%h/%b",
                         b, ifc.out_valid, ifc.in_ready, ifc.out_r, ifc.out_last,
                         pack(norm_o[2*b], norm_o[2*b+1]), (b == 3));
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_end: got ready=%b valid=%b want 1/0", ifc.in_ready,
                     ifc.out_valid);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        n_checks++;
        if (ifc.err_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %b want 1", ifc.err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        // One beat of a node is already held from the overflow scenario.
        put_beat(pack(5, -3), 1'b0);
        put_beat(pack(7, -2), 1'b0);
        put_beat(pack(9, 4), 1'b1);
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.err_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got valid=%b err=%b want 1/1", ifc.out_valid, ifc.err_ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.err_ovf !== 1'b0 ||
            ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b ready=%b err=%b busy=%b want 0/1/0/0",
                     ifc.out_valid, ifc.in_ready, ifc.err_ovf, ifc.busy);
        end
        n_checks++;
        if (ifc.out_r !== 16'h0 || ifc.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_out: got r=%h last=%b want 0000/0", ifc.out_r, ifc.out_last);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef CNU_OFFSET_EN
    task automatic test_offset();
        logic [15:0] d;
        logic        l;
        ifc.mode = 1'b1;
        ifc.beta = 7'd1;
        put_beat(pack(norm_q[0], norm_q[1]), 1'b0);
        ifc.mode = 1'b0;
        ifc.beta = 7'd0;
        for (int b = 1; b < 3; b++) put_beat(pack(norm_q[2*b], norm_q[2*b+1]), 1'b0);
        put_beat(pack(norm_q[6], norm_q[7]), 1'b1);
        for (int b = 0; b < 4; b++) begin
            get_beat(d, l);
            n_checks++;
            if (d !== pack(norm_o[2*b], norm_o[2*b+1]) || l !== (b == 3)) begin
                n_fail++;
                $display("FAIL ofs_beat%0d: got r=%h last=%b want r=%h last=%b", b, d, l,
                         pack(norm_o[2*b], norm_o[2*b+1]), (b == 3));
            end
        end
        ifc.mode = 1'b1;
        ifc.beta = 7'd1;
        put_beat(pack(-128, 20), 1'b1);
        get_beat(d, l);
        n_checks++;
        if (d !== pack(19, -126) || l !== 1'b1) begin
            n_fail++;
            $display("FAIL ofs_sat: got r=%h last=%b want r=%h last=1", d, l, pack(19, -126));
        end
        ifc.mode = 1'b0;
        ifc.beta = 7'd0;
    endtask
`endif

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_q      = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
`ifdef CNU_OFFSET_EN
        ifc.mode      = 1'b0;
        ifc.beta      = '0;
`endif
        test_reset();
        test_normalized();
        test_saturation();
        test_tie();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_tie();
`ifdef CNU_OFFSET_EN
        test_offset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
